// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side stream adapter.
//   - Default word and transfer-counter widths.
//   - Occupancy state enum for the 2-entry skid buffer.
//   - occ_of(): maps an occupancy state to its word count (0..2).
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_e;

  // Number of words held in the skid buffer for a given occupancy state.
  function automatic logic [1:0] occ_of(input occ_state_e s);
    case (s)
      S_ONE:   return 2'd1;
      S_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry skid buffer that turns captured FIFO words into a registered
// valid/ready stream. buf0 is the head (drives m_data_o), buf1 is the overflow
// slot used while downstream stalls.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   flush_i      synchronous discard of everything held
//   capture_i    fifo data on din_i must be stored this edge
//   din_i        word to capture
//   m_ready_i    downstream accept
//   m_valid_o    registered stream valid
//   m_data_o     registered stream data (head of buffer)
//   pop_o        a transfer completes on this edge (m_valid_o && m_ready_i)
//   occ_o        current number of words held (0..2)
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  pop_o,
  output logic [1:0]            occ_o
);

  occ_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  valid_q, valid_d;
  logic [1:0]            occ;
  logic [1:0]            occAfterPop;

  assign occ         = occ_of(state_q);
  assign pop_o       = valid_q && m_ready_i;
  assign occAfterPop = occ - {1'b0, pop_o};

  assign occ_o     = occ;
  assign m_valid_o = valid_q;
  assign m_data_o  = buf0_q;

  // Next-state logic. A pop from a full buffer shifts buf1 into the head; a
  // capture then lands in the first slot left free after that pop. Capturing
  // into a full, non-popping buffer cannot happen because reads are only
  // issued when there is guaranteed room, so S_TWO simply holds in that case.
  // Flush empties the buffer regardless of any capture or pop.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;

    if (pop_o && (state_q == S_TWO)) begin
      buf0_d = buf1_q;
    end

    if (capture_i) begin
      if (occAfterPop == 2'd0) begin
        buf0_d = din_i;
      end else begin
        buf1_d = din_i;
      end
    end

    case (state_q)
      S_EMPTY: begin
        if (capture_i) state_d = S_ONE;
      end
      S_ONE: begin
        if (capture_i && !pop_o)      state_d = S_TWO;
        else if (!capture_i && pop_o) state_d = S_EMPTY;
      end
      S_TWO: begin
        if (pop_o && !capture_i) state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase

    if (flush_i) begin
      state_d = S_EMPTY;
    end

    valid_d = (state_d != S_EMPTY);
  end

  // State and data registers; valid is kept in its own flop so m_valid_o is a
  // clean registered output rather than a decode of the state bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      buf0_q  <= '0;
      buf1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side adapter for the synchronous FIFO. Issues FIFO reads, absorbs the
// one-cycle registered read latency, and presents the words as a valid/ready
// stream at one word per cycle. Also provides a synchronous flush and a
// wrapping transfer counter.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en   FIFO read enable (combinational)
//   m_valid      stream valid (registered)
//   m_data       stream data (registered)
//   m_ready      downstream accept
//   flush        discard buffered and in-flight words
//   xfer_cnt     number of completed stream transfers, wraps
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] xferCnt_q, xferCnt_d;
  logic                 capture;
  logic                 pop;
  logic                 readIssue;
  logic                 hasRoom;
  logic [1:0]           occ;
  logic [2:0]           committed;

  // Words already committed to the buffer: those held plus the one arriving
  // from the FIFO. A new read is safe only if, after this edge's pop, fewer
  // than two are committed, so the buffer can never overflow.
  assign committed = {1'b0, occ} + {2'b00, inflight_q};
  assign hasRoom   = committed < (3'd2 + {2'b00, pop});
  assign readIssue = !flush && !fifo_empty && hasRoom;

  // rst_n only gates the external enable; the inflight flop is held by the
  // asynchronous reset anyway, so it is fed from the ungated term.
  assign fifo_rd_en = rst_n && readIssue;

  // A word returning from the FIFO is dropped if a flush lands on its edge.
  assign capture  = inflight_q && !flush;
  assign xfer_cnt = xferCnt_q;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .capture_i (capture),
    .din_i     (fifo_dout),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .pop_o     (pop),
    .occ_o     (occ)
  );

  // The inflight flag follows the read enable one cycle later; flush already
  // blocks the read, which clears it. The counter advances on every pop,
  // including a pop that coincides with a flush, and wraps naturally.
  always_comb begin
    inflight_d = readIssue;
    xferCnt_d  = xferCnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
  end

  // Read-tracking and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      xferCnt_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      xferCnt_q  <= xferCnt_d;
    end
  end

endmodule
